// File: rtl/motoro3_pkg.sv
// Shared types and constants for the motoro3 12-step commutation sequencer.
// Holds the state encoding, step and length constants and the length clamp helper.
package motoro3_pkg;

    localparam int CNT_W  = 25;
    localparam int STEP_W = 4;
    localparam int CYC_W  = 16;

    localparam logic [STEP_W-1:0] STEP_IDLE  = 4'd15;
    localparam logic [STEP_W-1:0] STEP_LAST  = 4'd11;
    localparam logic [STEP_W-1:0] STEP_HALF  = 4'd5;
    localparam logic [STEP_W-1:0] STEP_FIRST = 4'd0;
    localparam logic [STEP_W-1:0] STEP_ONE   = 4'd1;

    localparam logic [CNT_W-1:0] STEP_LEN_MIN = 25'd4;
    localparam logic [CNT_W-1:0] CNT_ONE      = 25'd1;
    localparam logic [CNT_W-1:0] CNT_TWO      = 25'd2;

    localparam logic [CYC_W-1:0] CYC_ONE = 16'd1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } seq_state_e;

    // Short lengths are raised so First2/First1/Last2/Last1 never coincide.
    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
        return (len < STEP_LEN_MIN) ? STEP_LEN_MIN : len;
    endfunction

endpackage

// File: rtl/motoro3_step_strobe_decode.sv
// Step-position strobe decode: purely combinational from the in-step counter,
// the latched step length and the active flag; no latency, no flow control.
module motoro3_step_strobe_decode
    import motoro3_pkg::*;
(
    input  logic [CNT_W-1:0] m3cnt_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             active_i,
    output logic             first2_o,
    output logic             first1_o,
    output logic             last2_o,
    output logic             last1_o
);

    assign first2_o = active_i && (m3cnt_i == (len_i - CNT_ONE));
    assign first1_o = active_i && (m3cnt_i == (len_i - CNT_TWO));
    assign last2_o  = active_i && (m3cnt_i == CNT_ONE);
    assign last1_o  = active_i && (m3cnt_i == '0);

endmodule

// File: rtl/motoro3_step_sequencer.sv
// 12-step commutation sequencer: state updates on the falling clock edge; strobes and
// flags decode combinationally from registered state. runEn is a level, no backpressure.
module motoro3_step_sequencer
    import motoro3_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              runEn,
    input  logic [CNT_W-1:0]  m3r_stepLen,
    output logic [STEP_W-1:0] sgStep,
    output logic [CNT_W-1:0]  m3cnt,
    output logic              m3cntFirst2,
    output logic              m3cntFirst1,
    output logic              m3cntLast2,
    output logic              m3cntLast1,
    output logic              pwmActive1,
    output logic              pwmLastStep1,
    output logic [CYC_W-1:0]  cycleCnt
);

    seq_state_e        state_q;
    logic [STEP_W-1:0] step_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  len_q;
    logic [CYC_W-1:0]  cyc_q;

    logic [CNT_W-1:0]  len_d;
    seq_state_e        run_d;

    assign len_d = clamp_len(m3r_stepLen);
    assign run_d = runEn ? ST_RUN : ST_STOPPING;

    // RUN and STOPPING count identically; runEn is only consulted at the step-11 boundary.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            step_q  <= STEP_IDLE;
            cnt_q   <= '0;
            len_q   <= STEP_LEN_MIN;
            cyc_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (runEn) begin
                        state_q <= ST_RUN;
                        step_q  <= STEP_FIRST;
                        cnt_q   <= len_d - CNT_ONE;
                        len_q   <= len_d;
                    end
                end
                default: begin
                    if (cnt_q != '0) begin
                        state_q <= run_d;
                        cnt_q   <= cnt_q - CNT_ONE;
                    end else if (step_q == STEP_LAST) begin
                        cyc_q <= cyc_q + CYC_ONE;
                        if (!runEn) begin
                            state_q <= ST_IDLE;
                            step_q  <= STEP_IDLE;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ST_RUN;
                            step_q  <= STEP_FIRST;
                            cnt_q   <= len_d - CNT_ONE;
                            len_q   <= len_d;
                        end
                    end else begin
                        state_q <= run_d;
                        step_q  <= step_q + STEP_ONE;
                        cnt_q   <= len_d - CNT_ONE;
                        len_q   <= len_d;
                    end
                end
            endcase
        end
    end

    assign sgStep       = step_q;
    assign m3cnt        = cnt_q;
    assign cycleCnt     = cyc_q;
    assign pwmActive1   = (state_q != ST_IDLE);
    assign pwmLastStep1 = pwmActive1 && ((step_q == STEP_HALF) || (step_q == STEP_LAST));

    motoro3_step_strobe_decode u_strobe (
        .m3cnt_i  (cnt_q),
        .len_i    (len_q),
        .active_i (pwmActive1),
        .first2_o (m3cntFirst2),
        .first1_o (m3cntFirst1),
        .last2_o  (m3cntLast2),
        .last1_o  (m3cntLast1)
    );

endmodule

// File: tb/tb_motoro3_step_sequencer.sv
// Directed bench for motoro3_step_sequencer with a cycle-level reference model
// feeding an expected-output queue; DUT updates on negedge, outputs sampled on posedge.
module tb_motoro3_step_sequencer;

    typedef struct packed {
        logic [3:0]  step;
        logic [24:0] cnt;
        logic        f2;
        logic        f1;
        logic        l2;
        logic        l1;
        logic        act;
        logic        last;
        logic [15:0] cyc;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        runEn;
    logic [24:0] m3r_stepLen;
    logic [3:0]  sgStep;
    logic [24:0] m3cnt;
    logic        m3cntFirst2;
    logic        m3cntFirst1;
    logic        m3cntLast2;
    logic        m3cntLast1;
    logic        pwmActive1;
    logic        pwmLastStep1;
    logic [15:0] cycleCnt;

    int vectors    = 0;
    int miscompares = 0;

    obs_t exp_q[$];

    // Reference model: position counts up from the start of the step.
    logic        m_run;
    int          m_step;
    int          m_pos;
    int          m_len;
    logic [15:0] m_cyc;

    motoro3_step_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .runEn        (runEn),
        .m3r_stepLen  (m3r_stepLen),
        .sgStep       (sgStep),
        .m3cnt        (m3cnt),
        .m3cntFirst2  (m3cntFirst2),
        .m3cntFirst1  (m3cntFirst1),
        .m3cntLast2   (m3cntLast2),
        .m3cntLast1   (m3cntLast1),
        .pwmActive1   (pwmActive1),
        .pwmLastStep1 (pwmLastStep1),
        .cycleCnt     (cycleCnt)
    );

    always #50 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic obs_t sample();
        return {sgStep, m3cnt, m3cntFirst2, m3cntFirst1, m3cntLast2, m3cntLast1,
                pwmActive1, pwmLastStep1, cycleCnt};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clock(input logic r, input logic [24:0] len);
        int len_e;
        len_e = (len < 25'd4) ? 4 : int'(len);
        if (!m_run) begin
            if (r) begin
                m_run  = 1'b1;
                m_step = 0;
                m_pos  = 0;
                m_len  = len_e;
            end
        end else if (m_pos == m_len - 1) begin
            m_pos = 0;
            m_len = len_e;
            if (m_step == 11) begin
                m_cyc = m_cyc + 16'd1;
                if (!r) m_run = 1'b0;
                else    m_step = 0;
            end else begin
                m_step++;
            end
        end else begin
            m_pos++;
        end
    endtask

    function automatic obs_t model_expect();
        obs_t e;
        e = '0;
        e.cyc = m_cyc;
        if (!m_run) begin
            e.step = 4'd15;
        end else begin
            e.step = 4'(m_step);
            e.cnt  = 25'(m_len - 1 - m_pos);
            e.f2   = (m_pos == 0);
            e.f1   = (m_pos == 1);
            e.l2   = (m_pos == m_len - 2);
            e.l1   = (m_pos == m_len - 1);
            e.act  = 1'b1;
            e.last = (m_step == 5) || (m_step == 11);
        end
        return e;
    endfunction

    // One falling edge of DUT activity, compared at the following rising edge.
    task automatic tick(input logic r, input logic [24:0] len);
        runEn       = r;
        m3r_stepLen = len;
        model_clock(r, len);
        exp_q.push_back(model_expect());
        @(posedge clk);
        check("cycle", 64'(sample()), 64'(exp_q.pop_front()));
    endtask

    initial begin
        obs_t        rst_exp;
        int          n_step0;
        int          n_last;
        int          n2;
        int          n3;
        int          c_f2;
        int          c_f1;
        int          c_l2;
        int          c_l1;
        logic [24:0] cl;

        rst_exp      = '0;
        rst_exp.step = 4'd15;
        m_run = 1'b0; m_step = 0; m_pos = 0; m_len = 4; m_cyc = '0;

        rst = 1'b1; runEn = 1'b0; m3r_stepLen = 25'd10;
        #20;
        check("reset_state", 64'(sample()), 64'(rst_exp));
        @(posedge clk);
        rst = 1'b0;
        tick(1'b0, 25'd10);
        tick(1'b0, 25'd10);

        // L=10 from idle: step 0 timing, wrap, pwmLastStep1 duty.
        n_step0 = 0; n_last = 0;
        for (int i = 1; i <= 121; i++) begin
            tick(1'b1, 25'd10);
            if (i <= 10 && sgStep == 4'd0) n_step0++;
            if (i <= 120 && pwmLastStep1) n_last++;
            if (i == 11) check("step1_on_11th", 64'(sgStep), 64'd1);
        end
        check("step0_clocks", 64'(n_step0), 64'd10);
        check("last_step_clocks", 64'(n_last), 64'd20);
        check("cycle_after_wrap", 64'(cycleCnt), 64'd1);
        check("wrap_to_step0", 64'(sgStep), 64'd0);

        // Length change 10 -> 20 in the middle of step 2, then run to step 7 m3cnt=5.
        n2 = 0; n3 = 0; cl = 25'd10;
        for (int i = 0; i < 400; i++) begin
            tick(1'b1, cl);
            if (sgStep == 4'd2) n2++;
            if (sgStep == 4'd3) n3++;
            if (sgStep == 4'd2 && m3cnt == 25'd6) cl = 25'd20;
            if (sgStep == 4'd7 && m3cnt == 25'd5) break;
        end
        check("step2_len", 64'(n2), 64'd10);
        check("step3_len", 64'(n3), 64'd20);
        check("reach_s7_c5", 64'({sgStep, m3cnt}), 64'({4'd7, 25'd5}));

        // Asynchronous reset well before the next falling edge.
        #10 rst = 1'b1;
        #1;
        check("async_reset", 64'(sample()), 64'(rst_exp));
        m_run = 1'b0; m_cyc = '0;
        #10 rst = 1'b0;
        tick(1'b0, 25'd2);

        // Clamped length: 4 clocks per step, each strobe once.
        c_f2 = 0; c_f1 = 0; c_l2 = 0; c_l1 = 0;
        for (int i = 1; i <= 8; i++) begin
            tick(1'b1, 25'd2);
            if (i <= 4) begin
                c_f2 += int'(m3cntFirst2);
                c_f1 += int'(m3cntFirst1);
                c_l2 += int'(m3cntLast2);
                c_l1 += int'(m3cntLast1);
            end
            if (i == 5) check("clamp_step_boundary", 64'(sgStep), 64'd1);
        end
        check("clamp_first2", 64'(c_f2), 64'd1);
        check("clamp_first1", 64'(c_f1), 64'd1);
        check("clamp_last2", 64'(c_l2), 64'd1);
        check("clamp_last1", 64'(c_l1), 64'd1);

        // Drop runEn in step 3 and let the cycle drain into idle.
        for (int i = 0; i < 200 && sgStep != 4'd3; i++) tick(1'b1, 25'd10);
        for (int i = 0; i < 200 && sgStep != 4'd15; i++) tick(1'b0, 25'd10);
        check("stop_idle_step", 64'(sgStep), 64'd15);
        check("stop_idle_cycles", 64'(cycleCnt), 64'd1);

        // Drop in step 3, re-assert in step 8: the cycle must continue past step 11.
        for (int i = 0; i < 200 && sgStep != 4'd3; i++) tick(1'b1, 25'd10);
        for (int i = 0; i < 200 && sgStep != 4'd8; i++) tick(1'b0, 25'd10);
        for (int i = 0; i < 200 && sgStep != 4'd0; i++) tick(1'b1, 25'd10);
        check("resume_active", 64'(pwmActive1), 64'd1);
        check("resume_step0", 64'(sgStep), 64'd0);
        check("resume_cycles", 64'(cycleCnt), 64'd2);
        for (int i = 0; i < 200 && sgStep != 4'd15; i++) tick(1'b0, 25'd10);
        check("final_idle", 64'(sample()), 64'({4'd15, 25'd0, 6'd0, 16'd3}));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
